// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side view of the ID-stage hazard controller: ID/EX hazard inputs
// going in, stall/flush controls and status coming back.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 16
);
    logic             ID_Valid;
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRt;
    logic             ID_IsMulDiv;
    logic             ID_ReadsHiLo;
    logic             EX_MemRead;
    logic [4:0]       EX_WR_out;
    logic             EX_BranchTaken;

    logic             PCWrite;
    logic             IFID_Write;
    logic             IDEX_Bubble;
    logic             IFID_Flush;
    logic             MD_Start;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cnt;

    // pipeline side: presents the hazard inputs, consumes the controls
    modport master (
        output ID_Valid, ID_Rs, ID_Rt, ID_UsesRt, ID_IsMulDiv, ID_ReadsHiLo,
               EX_MemRead, EX_WR_out, EX_BranchTaken,
        input  PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, MD_Start,
               md_busy, stall_cnt
    );

    // hazard unit side
    modport slave (
        input  ID_Valid, ID_Rs, ID_Rt, ID_UsesRt, ID_IsMulDiv, ID_ReadsHiLo,
               EX_MemRead, EX_WR_out, EX_BranchTaken,
        output PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, MD_Start,
               md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/flush controller: load-use and MUL/DIV occupancy stalls,
// taken-branch flush, MUL/DIV start pulse and a saturating stall counter.
//
// state | meaning
// RUN   | MUL/DIV unit idle, a muldiv in ID may issue
// BUSY  | MUL/DIV unit occupied, md_cnt_q counts remaining busy cycles
module hazard_stall_unit #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_stall_unit_if.slave hz
);
    typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

    // busy cycles remaining after the start cycle
    localparam logic [3:0] MD_RELOAD = 4'(MD_LAT - 1);

    state_t           state_q, state_d;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic md_busy;
    logic lu, md, stall;
    logic pc_write, ifid_write, idex_bubble, ifid_flush, md_start;

    assign md_busy = (state_q == BUSY);

    // hazard detection terms
    always_comb begin
        lu = hz.ID_Valid & hz.EX_MemRead & (hz.EX_WR_out != 5'd0) &
             ((hz.EX_WR_out == hz.ID_Rs) |
              (hz.ID_UsesRt & (hz.EX_WR_out == hz.ID_Rt)));
        md    = hz.ID_Valid & md_busy & (hz.ID_IsMulDiv | hz.ID_ReadsHiLo);
        stall = (lu | md) & ~hz.EX_BranchTaken;
    end

    // occupancy state register; reset abandons any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // next-state: load on start, count down, leave BUSY at terminal count
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            RUN: begin
                if (md_start) begin
                    state_d  = BUSY;
                    md_cnt_d = MD_RELOAD;
                end
            end
            BUSY: begin
                if (md_cnt_q == 4'd1) begin
                    state_d  = RUN;
                    md_cnt_d = 4'd0;
                end else begin
                    md_cnt_d = md_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = 4'd0;
            end
        endcase
    end

    // pipeline controls: flush beats stall beats run; reset holds the pipe frozen
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        md_start    = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (hz.EX_BranchTaken) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            md_start = hz.ID_Valid & hz.ID_IsMulDiv;
        end
    end

    // saturating stall counter next value; flush cycles never count
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // stall counter register, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign hz.PCWrite     = pc_write;
    assign hz.IFID_Write  = ifid_write;
    assign hz.IDEX_Bubble = idex_bubble;
    assign hz.IFID_Flush  = ifid_flush;
    assign hz.MD_Start    = md_start;
    assign hz.md_busy     = md_busy;
    assign hz.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// cycle-indexed behavioural model.
module tb_hazard_stall_unit;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int OW     = 6 + CNT_W;

    logic clk = 1'b0;
    logic rst;

    hazard_stall_unit_if #(.CNT_W(CNT_W)) hz ();

    hazard_stall_unit #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int err = 0;

    // model state: cycle index since reset, cycle of last MUL/DIV start, stall count
    int cyc          = 0;
    int md_start_cyc = -100;
    int m_cnt        = 0;

    function automatic logic m_busy();
        return ((cyc - md_start_cyc) >= 1) && ((cyc - md_start_cyc) <= MD_LAT - 1);
    endfunction

    function automatic logic m_lu();
        return hz.ID_Valid && hz.EX_MemRead && (hz.EX_WR_out != 5'd0) &&
               ((hz.EX_WR_out == hz.ID_Rs) || (hz.ID_UsesRt && (hz.EX_WR_out == hz.ID_Rt)));
    endfunction

    function automatic logic m_stall();
        logic md;
        md = hz.ID_Valid && m_busy() && (hz.ID_IsMulDiv || hz.ID_ReadsHiLo);
        return (m_lu() || md) && !hz.EX_BranchTaken;
    endfunction

    function automatic logic m_start();
        return !hz.EX_BranchTaken && !m_stall() && hz.ID_Valid && hz.ID_IsMulDiv;
    endfunction

    // {PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, MD_Start, md_busy, stall_cnt}
    function automatic logic [OW-1:0] m_out();
        logic [CNT_W-1:0] c;
        c = CNT_W'(m_cnt);
        if (rst)               return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {CNT_W{1'b0}}};
        if (hz.EX_BranchTaken) return {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, m_busy(), c};
        if (m_stall())         return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_busy(), c};
        return {1'b1, 1'b1, 1'b0, 1'b0, m_start(), m_busy(), c};
    endfunction

    // model advance at each edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc          <= 0;
            md_start_cyc <= -100;
            m_cnt        <= 0;
        end else begin
            if (m_start()) md_start_cyc <= cyc;
            if (m_stall() && (m_cnt < (2 ** CNT_W) - 1)) m_cnt <= m_cnt + 1;
            cyc <= cyc + 1;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        logic [OW-1:0] act, exp;
        act = {hz.PCWrite, hz.IFID_Write, hz.IDEX_Bubble, hz.IFID_Flush,
               hz.MD_Start, hz.md_busy, hz.stall_cnt};
        exp = m_out();
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL model_cycle t=%0t actual=%b required=%b", $time, act, exp);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        hz.ID_Valid       = 1'b0;
        hz.ID_Rs          = 5'd0;
        hz.ID_Rt          = 5'd0;
        hz.ID_UsesRt      = 1'b0;
        hz.ID_IsMulDiv    = 1'b0;
        hz.ID_ReadsHiLo   = 1'b0;
        hz.EX_MemRead     = 1'b0;
        hz.EX_WR_out      = 5'd0;
        hz.EX_BranchTaken = 1'b0;
    endtask

    task automatic set_load_use();
        idle();
        hz.ID_Valid   = 1'b1;
        hz.ID_Rs      = 5'd8;
        hz.EX_MemRead = 1'b1;
        hz.EX_WR_out  = 5'd8;
    endtask

    task automatic set_mult();
        idle();
        hz.ID_Valid    = 1'b1;
        hz.ID_IsMulDiv = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk("rst_pcwrite", 16'(hz.PCWrite), 16'd0);
        chk("rst_bubble", 16'(hz.IDEX_Bubble), 16'd1);
        chk("rst_cnt", 16'(hz.stall_cnt), 16'd0);
        repeat (2) step();
        rst = 1'b0;

        // load-use on Rs: one stall cycle
        step(); set_load_use(); #2;
        chk("lu_pcwrite", 16'(hz.PCWrite), 16'd0);
        chk("lu_ifidwrite", 16'(hz.IFID_Write), 16'd0);
        chk("lu_bubble", 16'(hz.IDEX_Bubble), 16'd1);
        step(); hz.EX_MemRead = 1'b0; #2;
        chk("lu_release", 16'(hz.PCWrite), 16'd1);
        chk("lu_cnt", 16'(hz.stall_cnt), 16'd1);

        // Rt match only matters when Rt is used; r0 never stalls
        step(); idle(); hz.ID_Valid = 1'b1; hz.ID_Rs = 5'd3; hz.ID_Rt = 5'd8;
        hz.EX_MemRead = 1'b1; hz.EX_WR_out = 5'd8; #2;
        chk("rt_unused", 16'(hz.PCWrite), 16'd1);
        step(); hz.ID_UsesRt = 1'b1; #2;
        chk("rt_used", 16'(hz.PCWrite), 16'd0);
        step(); hz.ID_UsesRt = 1'b0; hz.EX_WR_out = 5'd0; hz.ID_Rs = 5'd0; #2;
        chk("r0_nostall", 16'(hz.PCWrite), 16'd1);
        chk("rt_cnt", 16'(hz.stall_cnt), 16'd2);

        // MULT then MFLO waits out the busy window
        step(); set_mult(); #2;
        chk("md_start", 16'(hz.MD_Start), 16'd1);
        chk("md_busy_c0", 16'(hz.md_busy), 16'd0);
        step(); hz.ID_IsMulDiv = 1'b0; hz.ID_ReadsHiLo = 1'b1; #2;
        for (int i = 1; i <= 3; i++) begin
            chk("md_busy_win", 16'(hz.md_busy), 16'd1);
            chk("mflo_stall", 16'(hz.PCWrite), 16'd0);
            step();
            #2;
        end
        chk("md_done", 16'(hz.md_busy), 16'd0);
        chk("mflo_release", 16'(hz.PCWrite), 16'd1);
        chk("md_cnt", 16'(hz.stall_cnt), 16'd5);

        // flush cancels a simultaneous load-use
        step(); set_load_use(); hz.EX_BranchTaken = 1'b1; #2;
        chk("fl_flush", 16'(hz.IFID_Flush), 16'd1);
        chk("fl_bubble", 16'(hz.IDEX_Bubble), 16'd1);
        chk("fl_pcwrite", 16'(hz.PCWrite), 16'd1);
        step(); idle(); #2;
        chk("fl_cnt", 16'(hz.stall_cnt), 16'd5);

        // branch during BUSY does not abort the operation
        step(); set_mult(); #2;
        step(); idle(); hz.EX_BranchTaken = 1'b1; #2;
        chk("br_busy1", 16'(hz.md_busy), 16'd1);
        step(); hz.EX_BranchTaken = 1'b0; #2;
        chk("br_busy2", 16'(hz.md_busy), 16'd1);
        step(); #2;
        chk("br_busy3", 16'(hz.md_busy), 16'd1);
        step(); #2;
        chk("br_free", 16'(hz.md_busy), 16'd0);

        // async reset in the middle of a MUL/DIV
        step(); set_mult();
        step(); idle();
        step(); #1; rst = 1'b1; #1;
        chk("ar_busy", 16'(hz.md_busy), 16'd0);
        chk("ar_cnt", 16'(hz.stall_cnt), 16'd0);
        chk("ar_bubble", 16'(hz.IDEX_Bubble), 16'd1);
        chk("ar_pcwrite", 16'(hz.PCWrite), 16'd0);
        step(); #1; rst = 1'b0;
        step(); set_mult(); #2;
        chk("ar_mdstart", 16'(hz.MD_Start), 16'd1);
        chk("ar_nostall", 16'(hz.PCWrite), 16'd1);

        // stall counter saturation
        step(); set_load_use();
        repeat (20) step();
        #2;
        chk("sat_15", 16'(hz.stall_cnt), 16'd15);
        step(); #2;
        chk("sat_hold", 16'(hz.stall_cnt), 16'd15);
        step(); idle();

        // randomized traffic with occasional resets
        repeat (3000) begin
            step();
            rst                  = ($urandom_range(0, 199) == 0);
            hz.ID_Valid          = ($urandom_range(0, 3) != 0);
            hz.ID_Rs             = 5'($urandom_range(0, 3));
            hz.ID_Rt             = 5'($urandom_range(0, 3));
            hz.ID_UsesRt         = 1'($urandom_range(0, 1));
            hz.ID_IsMulDiv       = ($urandom_range(0, 4) == 0);
            hz.ID_ReadsHiLo      = !hz.ID_IsMulDiv && ($urandom_range(0, 3) == 0);
            hz.EX_MemRead        = 1'($urandom_range(0, 1));
            hz.EX_WR_out         = 5'($urandom_range(0, 3));
            hz.EX_BranchTaken    = ($urandom_range(0, 9) == 0);
        end
        step(); rst = 1'b0; idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
